// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the DE10 key debounce/event block.
// Channel FSM states, key index width and a counter-width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP,
    WAIT_DN,
    DOWN,
    WAIT_UP
  } db_state_t;

  localparam int KEY_IDX_W = 2;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, counter debounce FSM, press/release pulses.
// Optional auto-repeat of the press pulse while held when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES            = 500000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES  = 20000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
`endif
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sync_pressed;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             accept_dn;
  logic             accept_up;
  logic             rep_fire;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign sync_pressed = ~sync2;

  always_comb begin
    accept_dn = (state == WAIT_DN) && sync_pressed && (cnt == CNT_LAST);
    accept_up = (state == WAIT_UP) && !sync_pressed && (cnt == CNT_LAST);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic [RPT_W-1:0] rcnt;
  logic             repeating;

  // The first repeat waits the long delay, later ones the shorter period.
  always_comb begin
    rep_fire = (state == DOWN) && sync_pressed &&
               (rcnt == (repeating ? PER_LAST : DLY_LAST));
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rcnt      <= '0;
      repeating <= 1'b0;
    end else if ((state == DOWN) && sync_pressed) begin
      if (rep_fire) begin
        rcnt      <= '0;
        repeating <= 1'b1;
      end else begin
        rcnt <= rcnt + RPT_W'(1);
      end
    end else begin
      rcnt      <= '0;
      repeating <= 1'b0;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign press_evt = accept_dn | rep_fire;

  // Counter only ever counts up to CNT_LAST; reaching it accepts the change.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= UP;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_evt;
      release_pulse <= accept_up;
      case (state)
        UP: begin
          if (sync_pressed) begin
            state <= WAIT_DN;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_DN: begin
          if (!sync_pressed) begin
            state <= UP;
            cnt   <= '0;
          end else if (accept_dn) begin
            state <= DOWN;
            cnt   <= '0;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DOWN: begin
          if (!sync_pressed) begin
            state <= WAIT_UP;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_UP: begin
          if (sync_pressed) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (accept_up) begin
            state <= UP;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_events.sv
// Debounces the active-low DE10 keys and latches the most recently pressed key index.
// Define KEY_AUTOREPEAT_EN to enable auto-repeat press pulses on held keys.
module key_debounce_events
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS             = 4,
  parameter int DB_CYCLES            = 500000,
  parameter int REPEAT_DELAY_CYCLES  = 20000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [NUM_KEYS-1:0]  key_n_in,
  output logic [NUM_KEYS-1:0]  key_level,
  output logic [NUM_KEYS-1:0]  key_press,
  output logic [NUM_KEYS-1:0]  key_release,
  output logic [KEY_IDX_W-1:0] key_dir,
  output logic                 key_dir_valid
);

  logic [NUM_KEYS-1:0]  press_evt;
  logic [KEY_IDX_W-1:0] dir_next;
  logic                 any_press;

  if (DB_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_cfg
    $error("key_debounce_events: invalid timing parameters");
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES            (DB_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
`endif
    ) u_ch (
      .clk_clk       (clk_clk),
      .reset_reset   (reset_reset),
      .key_n         (key_n_in[g]),
      .level         (key_level[g]),
      .press_pulse   (key_press[g]),
      .release_pulse (key_release[g]),
      .press_evt     (press_evt[g])
    );
  end

  // Scan from the top down so the lowest pressing index is the one kept.
  always_comb begin
    dir_next  = '0;
    any_press = |press_evt;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_evt[i]) dir_next = KEY_IDX_W'(i);
    end
  end

  // Driven from the same strobe as key_press so key_dir changes with the pulse.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_dir       <= '0;
      key_dir_valid <= 1'b0;
    end else if (any_press) begin
      key_dir       <= dir_next;
      key_dir_valid <= 1'b1;
    end
  end

endmodule
